// File: rtl/idma_desc64_arb_pkg.sv
// Width helpers shared by the descriptor submit arbiter and its completion-ID FIFO.
package idma_desc64_arb_pkg;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/idma_desc64_id_fifo.sv
// Records requester IDs in submit order so in-order completions can be routed back.
module idma_desc64_id_fifo
  import idma_desc64_arb_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = id_width(Depth);
  localparam int unsigned CntW = cnt_width(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PtrW-1:0] f_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      if (i_push && !i_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!i_push && i_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);

`ifndef SYNTHESIS
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && o_full));
`endif

endmodule

// File: rtl/idma_desc64_submit_arbiter.sv
// Round-robin arbiter feeding the descriptor FIFO, with an outstanding-descriptor
// credit limit and in-order routing of completion pulses back to requesters.
module idma_desc64_submit_arbiter
  import idma_desc64_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned MaxOutstanding = 8,
  localparam int unsigned IdW           = id_width(NumReq),
  localparam int unsigned CntW          = cnt_width(MaxOutstanding)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  output logic [AddrWidth-1:0]             desc_addr_o,
  output logic [IdW-1:0]                   desc_id_o,
  output logic                             desc_valid_o,
  input  logic                             desc_ready_i,
  input  logic                             desc_done_i,
  output logic                             done_valid_o,
  output logic [IdW-1:0]                   done_id_o,
  output logic [CntW-1:0]                  outstanding_o,
  output logic                             err_o
);

  localparam logic [CntW:0] MaxOut = (CntW+1)'(MaxOutstanding);

  logic [IdW-1:0]       r_rr_ptr;
  logic [AddrWidth-1:0] r_desc_addr;
  logic [IdW-1:0]       r_desc_id;
  logic                 r_desc_valid;
  logic                 r_done_valid;
  logic [IdW-1:0]       r_done_id;
  logic [CntW-1:0]      r_outstanding;
  logic                 r_err;

  logic [IdW-1:0] w_winner;
  logic           w_credit_ok;
  logic           w_load;
  logic           w_hs;
  logic           w_done;
  logic           w_spurious;
  logic [IdW-1:0] w_fifo_head;
  logic           w_fifo_full;
  logic           w_fifo_empty;

  // Credit counts the descriptor parked in the output register as already in flight.
  assign w_credit_ok = ({1'b0, r_outstanding} + {{CntW{1'b0}}, r_desc_valid}) < MaxOut;

  // Scan from lowest to highest priority so the last match is the winner.
  always_comb begin
    logic [IdW-1:0] cand;
    cand     = '0;
    w_winner = r_rr_ptr;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      cand = IdW'((int'(r_rr_ptr) + k) % int'(NumReq));
      if (req_valid_i[cand]) w_winner = cand;
    end
  end

  assign w_load     = (!r_desc_valid || desc_ready_i) && w_credit_ok && (|req_valid_i);
  assign w_hs       = r_desc_valid && desc_ready_i;
  assign w_done     = desc_done_i && (r_outstanding != '0);
  assign w_spurious = desc_done_i && (r_outstanding == '0);

  always_comb begin
    req_ready_o = '0;
    if (w_load) req_ready_o[w_winner] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr     <= '0;
      r_desc_addr  <= '0;
      r_desc_id    <= '0;
      r_desc_valid <= 1'b0;
    end else if (w_load) begin
      r_desc_addr  <= req_addr_i[w_winner];
      r_desc_id    <= w_winner;
      r_desc_valid <= 1'b1;
      r_rr_ptr     <= (w_winner == IdW'(NumReq - 1)) ? '0 : w_winner + IdW'(1);
    end else if (desc_ready_i) begin
      r_desc_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_done_valid  <= 1'b0;
      r_done_id     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_done_valid <= w_done;
      if (w_done)     r_done_id <= w_fifo_head;
      if (w_spurious) r_err     <= 1'b1;
      if (w_hs && !w_done) begin
        r_outstanding <= r_outstanding + CntW'(1);
      end else if (!w_hs && w_done) begin
        r_outstanding <= r_outstanding - CntW'(1);
      end
    end
  end

  idma_desc64_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdW)
  ) u_id_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_hs),
    .i_data  (r_desc_id),
    .i_pop   (w_done),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) w_fifo_empty == (r_outstanding == '0));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   w_fifo_full == (r_outstanding == CntW'(MaxOutstanding)));
`endif

  assign desc_addr_o   = r_desc_addr;
  assign desc_id_o     = r_desc_id;
  assign desc_valid_o  = r_desc_valid;
  assign done_valid_o  = r_done_valid;
  assign done_id_o     = r_done_id;
  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;

endmodule

// File: tb/tb_idma_desc64_submit_arbiter.sv
// Randomized and directed scoreboard bench for the descriptor submit arbiter.
module tb_idma_desc64_submit_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 64;
  localparam int MAXO = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    id;
  } expEntry_t;

  logic                  clk;
  logic                  rst_ni;
  logic [NR-1:0][AW-1:0] req_addr_i;
  logic [NR-1:0]         req_valid_i;
  logic [NR-1:0]         req_ready_o;
  logic [AW-1:0]         desc_addr_o;
  logic [1:0]            desc_id_o;
  logic                  desc_valid_o;
  logic                  desc_ready_i;
  logic                  desc_done_i;
  logic                  done_valid_o;
  logic [1:0]            done_id_o;
  logic [3:0]            outstanding_o;
  logic                  err_o;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model state, kept as plain integers and queues.
  int        mRr, mOut, mSlotId;
  bit        mValid, mErr, mDoneValid;
  int        mIdq[$];
  expEntry_t expQ[$];
  int        doneQ[$];
  int        grantLog[$];
  int        doneLog[$];
  int        hsCount = 0;
  logic [NR-1:0] pending;
  logic [AW-1:0] pendAddr[NR];
  logic [NR-1:0] lastReady;
  expEntry_t monEnt;
  int        fairExp[5] = '{0, 1, 2, 3, 0};
  int        routeExp[3] = '{2, 0, 3};

  idma_desc64_submit_arbiter #(
    .NumReq         (NR),
    .AddrWidth      (AW),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_addr_i    (req_addr_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .desc_addr_o   (desc_addr_o),
    .desc_id_o     (desc_id_o),
    .desc_valid_o  (desc_valid_o),
    .desc_ready_i  (desc_ready_i),
    .desc_done_i   (desc_done_i),
    .done_valid_o  (done_valid_o),
    .done_id_o     (done_id_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mRr = 0; mOut = 0; mSlotId = 0;
    mValid = 0; mErr = 0; mDoneValid = 0;
    mIdq.delete();
    expQ.delete();
    doneQ.delete();
  endtask

  // One cycle: present inputs, predict from the arbitration rules, check, advance the clock.
  task automatic applyStimulus(input logic [NR-1:0] newReq, input bit rdy, input bit done);
    bit        credit, load, hs, doneOk;
    int        winner;
    expEntry_t ent;
    for (int i = 0; i < NR; i++) begin
      if (!pending[i] && newReq[i]) begin
        pending[i]  = 1'b1;
        pendAddr[i] = {$urandom, $urandom};
      end
      req_addr_i[i] = pendAddr[i];
    end
    req_valid_i  = pending;
    desc_ready_i = rdy;
    desc_done_i  = done;
    #1;
    credit = (mOut + (mValid ? 1 : 0)) < MAXO;
    load   = (!mValid || rdy) && credit && (pending != '0);
    winner = -1;
    if (load) begin
      for (int k = 0; k < NR; k++) begin
        if (winner < 0 && pending[(mRr + k) % NR]) winner = (mRr + k) % NR;
      end
    end
    lastReady = req_ready_o;
    checkOutput("req_ready", 64'(req_ready_o), load ? 64'(1) << winner : 64'd0);
    hs     = mValid && rdy;
    doneOk = done && (mOut > 0);
    if (done && mOut == 0) mErr = 1;
    if (hs) mIdq.push_back(mSlotId);
    if (doneOk) doneQ.push_back(mIdq.pop_front());
    mOut       = mOut + (hs ? 1 : 0) - (doneOk ? 1 : 0);
    mDoneValid = doneOk;
    if (load) begin
      ent.addr = pendAddr[winner];
      ent.id   = 2'(winner);
      expQ.push_back(ent);
      mSlotId         = winner;
      mValid          = 1;
      mRr             = (winner + 1) % NR;
      pending[winner] = 1'b0;
    end else if (rdy) begin
      mValid = 0;
    end
    @(posedge clk);
    #1;
    checkOutput("outstanding", 64'(outstanding_o), 64'(mOut));
    checkOutput("desc_valid", 64'(desc_valid_o), 64'(mValid));
    checkOutput("err", 64'(err_o), 64'(mErr));
    checkOutput("done_valid", 64'(done_valid_o), 64'(mDoneValid));
  endtask

  task automatic drainAll();
    for (int n = 0; n < 80; n++) begin
      if (pending == '0 && !mValid && mOut == 0 && !mDoneValid) break;
      applyStimulus('0, 1'b1, mOut > 0);
    end
    checkOutput("drain_outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("drain_valid", 64'(desc_valid_o), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready_o), 64'd0);
    checkOutput({tag, "_desc_valid"}, 64'(desc_valid_o), 64'd0);
    checkOutput({tag, "_desc_addr"}, desc_addr_o, 64'd0);
    checkOutput({tag, "_desc_id"}, 64'(desc_id_o), 64'd0);
    checkOutput({tag, "_done_valid"}, 64'(done_valid_o), 64'd0);
    checkOutput({tag, "_done_id"}, 64'(done_id_o), 64'd0);
    checkOutput({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    checkOutput({tag, "_err"}, 64'(err_o), 64'd0);
  endtask

  // Monitor: every output handshake and completion pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (desc_valid_o && desc_ready_i) begin
        hsCount++;
        grantLog.push_back(int'(desc_id_o));
        checkOutput("handshake_expected", 64'(expQ.size() > 0), 64'd1);
        if (expQ.size() > 0) begin
          monEnt = expQ.pop_front();
          checkOutput("desc_addr", desc_addr_o, monEnt.addr);
          checkOutput("desc_id", 64'(desc_id_o), 64'(monEnt.id));
        end
      end
      if (done_valid_o) begin
        doneLog.push_back(int'(done_id_o));
        checkOutput("done_expected", 64'(doneQ.size() > 0), 64'd1);
        if (doneQ.size() > 0) checkOutput("done_id", 64'(done_id_o), 64'(doneQ.pop_front()));
      end
    end
  end

  initial begin
    logic [AW-1:0] capAddr;
    logic [1:0]    capId;
    int            hsBase;
    logic [3:0]    outBefore;

    rst_ni       = 1'b0;
    pending      = '0;
    req_valid_i  = '0;
    req_addr_i   = '0;
    desc_ready_i = 1'b0;
    desc_done_i  = 1'b0;
    for (int i = 0; i < NR; i++) pendAddr[i] = '0;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("init");
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] round-robin fairness");
    grantLog.delete();
    for (int n = 0; n < 6; n++) applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("fair_count", 64'(grantLog.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < grantLog.size()) checkOutput("fair_order", 64'(grantLog[i]), 64'(fairExp[i]));
    end
    drainAll();

    $display("[TB] credit limit");
    hsBase = hsCount;
    for (int n = 0; n < 12; n++) applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("credit_handshakes", 64'(hsCount - hsBase), 64'd8);
    checkOutput("credit_outstanding", 64'(outstanding_o), 64'd8);
    checkOutput("credit_ready_low", 64'(req_ready_o), 64'd0);
    applyStimulus('0, 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("credit_regrant", 64'(lastReady != '0), 64'd1);
    drainAll();

    $display("[TB] backpressure");
    applyStimulus(4'hF, 1'b1, 1'b0);
    capAddr = desc_addr_o;
    capId   = desc_id_o;
    for (int n = 0; n < 5; n++) begin
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("bp_addr_stable", desc_addr_o, capAddr);
      checkOutput("bp_id_stable", 64'(desc_id_o), 64'(capId));
      checkOutput("bp_no_ready", 64'(lastReady), 64'd0);
    end
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("bp_next_grant", 64'(lastReady), 64'(1) << ((int'(capId) + 1) % NR));
    drainAll();

    $display("[TB] completion routing");
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);
    doneLog.delete();
    for (int n = 0; n < 3; n++) applyStimulus('0, 1'b1, 1'b1);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("route_count", 64'(doneLog.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < doneLog.size()) checkOutput("route_order", 64'(doneLog[i]), 64'(routeExp[i]));
    end
    applyStimulus(4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    outBefore = outstanding_o;
    checkOutput("same_cycle_before", 64'(outBefore), 64'd1);
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("same_cycle_after", 64'(outstanding_o), 64'd1);
    drainAll();

    $display("[TB] spurious completion");
    applyStimulus('0, 1'b1, 1'b1);
    checkOutput("spurious_err", 64'(err_o), 64'd1);
    checkOutput("spurious_no_done", 64'(done_valid_o), 64'd0);
    for (int n = 0; n < 3; n++) applyStimulus('0, 1'b1, 1'b0);
    checkOutput("spurious_sticky", 64'(err_o), 64'd1);

    $display("[TB] reset mid-operation");
    for (int n = 0; n < 6; n++) applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("pre_reset_outstanding", 64'(outstanding_o), 64'd5);
    pending     = '0;
    req_valid_i = '0;
    desc_done_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checkResetValues("midreset");
    resetModel();
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b1;
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus(4'hF, 1'b1, 1'b0);
    checkOutput("post_reset_first_grant", 64'(lastReady), 64'd1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(NR'($urandom), $urandom_range(0, 3) != 0,
                    (mOut > 0) && ($urandom_range(0, 2) == 0));
    end
    drainAll();
    desc_done_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("expq_drained", 64'(expQ.size()), 64'd0);
    checkOutput("doneq_drained", 64'(doneQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/idma_desc64_submit_arbiter.md
# idma_desc64_submit_arbiter

Round-robin arbiter that shares the single descriptor-submission path of the 64-bit descriptor frontend among several requesters (harts or clusters), each presenting descriptor addresses over valid/ready. It sits in front of the descriptor FIFO input and enforces a global limit on outstanding descriptors. It also records the submit order, so that in-order completion pulses from the backend are routed back to the originating requester.

## Interface
- NumReq, 4: number of requester ports, ≥2.
- AddrWidth, 64: descriptor address width.
- MaxOutstanding, 8: maximum descriptors in flight, counted from output handshake until completion. Must be ≥1.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_addr_i  in  NumReq×AddrWidth  per-requester descriptor address.
- req_valid_i  in  NumReq  per-requester valid.
- req_ready_o  out  NumReq  per-requester ready; one-hot or zero.
- desc_addr_o  out  AddrWidth  granted address toward the descriptor FIFO.
- desc_id_o  out  IdW=$clog2(NumReq)  requester index of desc_addr_o.
- desc_valid_o  out  1  output valid.
- desc_ready_i  in  1  descriptor FIFO ready.
- desc_done_i  in  1  single-cycle pulse per completed descriptor; completions arrive in submit order.
- done_valid_o  out  1  completion pulse toward a requester.
- done_id_o  out  IdW  requester index for done_valid_o.
- outstanding_o  out  $clog2(MaxOutstanding+1)  descriptors in flight.
- err_o  out  1  sticky: desc_done_i received with nothing outstanding.

## Operation
- The output register holds one entry: addr, id and valid.
- **Output register loads** when (!desc_valid_o || desc_ready_i) && credit_ok && any req_valid_i.
- **credit_ok:** outstanding_q + desc_valid_o < MaxOutstanding, using register values only.
- **Round-robin grant:**
  - rr_ptr_q is the highest-priority index.
  - The first valid requester at or after rr_ptr_q, wrapping modulo NumReq, wins.
  - req_ready_o[winner] is asserted only when the load condition holds.
  - On a load, rr_ptr_q becomes (winner+1) mod NumReq. It is unchanged otherwise.
- **Requester rules:** a requester must hold addr and valid stable until ready. A non-granted requester sees ready=0.
- **Output handshake** (desc_valid_o && desc_ready_i):
  - the ID is pushed into the ID FIFO;
  - outstanding increments.
  - desc_addr_o and desc_id_o stay stable while desc_valid_o && !desc_ready_i.
- **Completion:** desc_done_i && outstanding_q>0 pops the ID FIFO, decrements outstanding, and registers done_valid_o=1 with done_id_o set to the popped ID.
- **Same-cycle handshake and completion:** outstanding is unchanged. The FIFO pushes and pops in the same cycle; pop returns the head, even when the FIFO holds one entry.
- **desc_done_i with outstanding_q==0:** ignored, no pop, err_o set. err_o is cleared only by reset.
- **ID FIFO depth:** MaxOutstanding. credit_ok prevents overflow, so no full check is needed on push. Assert (simulation-only) that push never occurs while full.
- **Reset mid-operation:** all state is dropped immediately: output register, ID FIFO, counters and pointer. In-flight completions after reset count as spurious and set err_o.

## Timing
- **Reset values:** req_ready_o=0, desc_valid_o=0, desc_addr_o=0, desc_id_o=0, done_valid_o=0, done_id_o=0, outstanding_o=0, err_o=0, rr_ptr_q=0.
- **Request latency:** a request handshake at cycle t gives desc_valid_o at t+1.
- **Throughput:** one descriptor per cycle with desc_ready_i held high, until the credit limit.
- **Completion latency:** desc_done_i at t gives done_valid_o at t+1 for exactly one cycle.
- **Credit latency:** outstanding_o reflects a handshake or completion one cycle later (registered). A credit freed by completion at t allows a grant at t+1.
- **Combinational paths:**
  - desc_ready_i → req_ready_o exists.
  - No path from req_valid_i to desc_valid_o.
  - No path from desc_done_i to any output.

## Structure
- **Package idma_desc64_arb_pkg:** the ID width helper and the outstanding-counter width function. Module parameters remain the source of values.
- **Sub-module idma_desc64_id_fifo:** synchronous FIFO, depth MaxOutstanding, width IdW, with push, pop, head and full/empty flags. Same-cycle push and pop is allowed at every fill level.
- **Top level:** holds the rr pointer, output register, outstanding counter and err flag. Use the codebase FF macros with asynchronous active-low reset.

## Test plan
- **Round-robin fairness:** all four valid, desc_ready_i=1 → grants in order 0,1,2,3,0, one per cycle; desc_id_o matches each cycle.
- **Credit limit:** MaxOutstanding=8, no completions → exactly 8 handshakes, then req_ready_o=0. One desc_done_i → one more grant the next cycle.
- **Backpressure:** desc_ready_i=0 for 5 cycles with desc_valid_o=1 → desc_addr_o/desc_id_o stable, no req_ready_o, rr_ptr unchanged.
- **Completion routing:** submit IDs 2,0,3, then three desc_done_i pulses → done_id_o 2,0,3 each one cycle after its pulse. Same-cycle handshake and done → outstanding unchanged.
- **Spurious completion:** desc_done_i with outstanding 0 → no done_valid_o, err_o=1 and sticky.
- **Reset mid-operation:** rst_ni low with 5 outstanding → all outputs at reset values asynchronously. After release, the first grant goes to requester 0.
